// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared command/state encodings and MRS field packing for the SDRAM init controller
package sdram_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_PRE,
        ST_TRP,
        ST_AR,
        ST_TRFC,
        ST_MRS,
        ST_TMRD,
        ST_DONE
    } state_e;

    // Low ten address bits of the mode register word; A10 and above are zero.
    function automatic logic [9:0] mrs_mode(input logic       write_mode,
                                            input logic [2:0] cas,
                                            input logic       addr_mode,
                                            input logic [2:0] bl);
        return {write_mode, 2'b00, cas, addr_mode, bl};
    endfunction

endpackage

// File: rtl/sdram_init_ctrl.sv
// rtl/sdram_init_ctrl.sv - SDRAM power-up init and mode-register reload sequencer
module sdram_init_ctrl
    import sdram_pkg::*;
#(
    parameter int          ADDR_W     = 13,
    parameter int          BANK_W     = 2,
    parameter int          CNT_WAIT   = 10000,
    parameter int          AR_NUM     = 8,
    parameter int          TRP_CYC    = 2,
    parameter int          TRFC_CYC   = 7,
    parameter int          TMRD_CYC   = 2,
    parameter logic [2:0]  CAS_LAT    = 3'b011,
    parameter logic [2:0]  BURST_LEN  = 3'b111,
    parameter logic        ADDR_MODE  = 1'b0,
    parameter logic        WRITE_MODE = 1'b0
) (
    input  logic              init_clk,
    input  logic              init_rst_n,
    input  logic              init_req,
    input  logic              mrs_req,
    input  logic [2:0]        mrs_cas,
    input  logic [2:0]        mrs_bl,
    output logic [3:0]        init_cmd,
    output logic [BANK_W-1:0] init_bank,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_end,
    output logic              init_busy,
    output logic              mrs_ack
);

    localparam int               WAIT_W    = $clog2(CNT_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CNT_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(CNT_WAIT);
    localparam logic [7:0]       TRP_LAST  = 8'(TRP_CYC - 1);
    localparam logic [7:0]       TRFC_LAST = 8'(TRFC_CYC - 1);
    localparam logic [7:0]       TMRD_LAST = 8'(TMRD_CYC - 1);
    localparam logic [3:0]       AR_TOTAL  = 4'(AR_NUM);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]          cyc_cnt_q, cyc_cnt_d;
    logic [3:0]          ar_cnt_q, ar_cnt_d;
    logic                reload_q, reload_d;
    logic [2:0]          cas_q, cas_d;
    logic [2:0]          bl_q, bl_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                end_q, end_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;

    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            ar_cnt_q   <= '0;
            reload_q   <= 1'b0;
            cas_q      <= CAS_LAT;
            bl_q       <= BURST_LEN;
            cmd_q      <= CMD_NOP;
            bank_q     <= '1;
            addr_q     <= '1;
            end_q      <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            ar_cnt_q   <= ar_cnt_d;
            reload_q   <= reload_d;
            cas_q      <= cas_d;
            bl_q       <= bl_d;
            cmd_q      <= cmd_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ar_cnt_d = ar_cnt_q;
        reload_d = reload_q;
        cas_d    = cas_q;
        bl_d     = bl_q;
        case (state_q)
            ST_WAIT: if (wait_cnt_q >= WAIT_LAST) state_d = ST_PRE;
            ST_PRE:  state_d = ST_TRP;
            ST_TRP:  if (cyc_cnt_q == TRP_LAST) state_d = reload_q ? ST_MRS : ST_AR;
            ST_AR: begin
                state_d = ST_TRFC;
                if (ar_cnt_q != 4'hF) ar_cnt_d = ar_cnt_q + 4'd1;
            end
            ST_TRFC: if (cyc_cnt_q == TRFC_LAST) state_d = (ar_cnt_q < AR_TOTAL) ? ST_AR : ST_MRS;
            ST_MRS:  state_d = ST_TMRD;
            ST_TMRD: if (cyc_cnt_q == TMRD_LAST) state_d = ST_DONE;
            ST_DONE: begin
                // A simultaneous mrs_req is dropped: full init takes priority.
                if (init_req) begin
                    state_d  = ST_WAIT;
                    reload_d = 1'b0;
                    ar_cnt_d = '0;
                    cas_d    = CAS_LAT;
                    bl_d     = BURST_LEN;
                end else if (mrs_req) begin
                    state_d  = ST_PRE;
                    reload_d = 1'b1;
                    ar_cnt_d = '0;
                    cas_d    = mrs_cas;
                    bl_d     = mrs_bl;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        wait_cnt_d = '0;
        if (state_q == ST_WAIT && state_d == ST_WAIT)
            wait_cnt_d = (wait_cnt_q < WAIT_MAX) ? wait_cnt_q + WAIT_W'(1) : wait_cnt_q;

        if (state_d != state_q)
            cyc_cnt_d = '0;
        else
            cyc_cnt_d = (cyc_cnt_q == 8'hFF) ? cyc_cnt_q : cyc_cnt_q + 8'd1;
    end

    always_comb begin
        cmd_d  = CMD_NOP;
        bank_d = '1;
        addr_d = '1;
        case (state_q)
            ST_PRE: cmd_d = CMD_PRE;
            ST_AR:  cmd_d = CMD_AR;
            ST_MRS: begin
                cmd_d  = CMD_MRS;
                bank_d = '0;
                addr_d = ADDR_W'(mrs_mode(WRITE_MODE, cas_q, ADDR_MODE, bl_q));
            end
            default: ;
        endcase
        end_d  = (state_q == ST_DONE);
        busy_d = (state_q != ST_DONE);
        // end_q still low marks the first DONE cycle, so ack lines up with init_end rising.
        ack_d  = (state_q == ST_DONE) && !end_q && reload_q;
    end

    assign init_cmd  = cmd_q;
    assign init_bank = bank_q;
    assign init_addr = addr_q;
    assign init_end  = end_q;
    assign init_busy = busy_q;
    assign mrs_ack   = ack_q;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// tb/tb_sdram_init_ctrl.sv - self-checking bench for sdram_init_ctrl against a per-cycle trace model
module tb_sdram_init_ctrl;

    localparam int CNT_WAIT = 20;
    localparam int AR_NUM   = 2;
    localparam int TRP_CYC  = 2;
    localparam int TRFC_CYC = 7;
    localparam int TMRD_CYC = 2;
    localparam int TAIL     = 3;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  bank;
        logic [12:0] addr;
        logic        ended;
        logic        busy;
        logic        ack;
    } rec_t;

    logic        init_clk = 1'b0;
    logic        init_rst_n = 1'b0;
    logic        init_req = 1'b0;
    logic        mrs_req = 1'b0;
    logic [2:0]  mrs_cas = 3'b000;
    logic [2:0]  mrs_bl = 3'b000;
    logic [3:0]  init_cmd;
    logic [1:0]  init_bank;
    logic [12:0] init_addr;
    logic        init_end;
    logic        init_busy;
    logic        mrs_ack;

    int total = 0;
    int bad = 0;
    rec_t exp_q[$];
    logic [2:0] m_cas, m_bl;

    sdram_init_ctrl #(
        .ADDR_W(13), .BANK_W(2), .CNT_WAIT(CNT_WAIT), .AR_NUM(AR_NUM),
        .TRP_CYC(TRP_CYC), .TRFC_CYC(TRFC_CYC), .TMRD_CYC(TMRD_CYC)
    ) dut (
        .init_clk(init_clk), .init_rst_n(init_rst_n), .init_req(init_req),
        .mrs_req(mrs_req), .mrs_cas(mrs_cas), .mrs_bl(mrs_bl),
        .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
        .init_end(init_end), .init_busy(init_busy), .mrs_ack(mrs_ack)
    );

    always #5 init_clk = ~init_clk;

    function automatic rec_t idle_rec();
        return '{cmd: 4'b0111, bank: 2'b11, addr: 13'h1FFF, ended: 1'b0, busy: 1'b1, ack: 1'b0};
    endfunction

    function automatic rec_t cmd_rec(input logic [3:0] c);
        rec_t r = idle_rec();
        r.cmd = c;
        return r;
    endfunction

    function automatic rec_t mrs_rec(input logic [2:0] cas, input logic [2:0] bl);
        rec_t r = idle_rec();
        r.cmd  = 4'b0000;
        r.bank = 2'b00;
        r.addr = 13'(cas * 16 + bl);
        return r;
    endfunction

    function automatic rec_t done_rec(input logic ack);
        return '{cmd: 4'b0111, bank: 2'b11, addr: 13'h1FFF, ended: 1'b1, busy: 1'b0, ack: ack};
    endfunction

    function automatic rec_t observed();
        return '{cmd: init_cmd, bank: init_bank, addr: init_addr,
                 ended: init_end, busy: init_busy, ack: mrs_ack};
    endfunction

    task automatic push_n(input int n, input rec_t r);
        for (int k = 0; k < n; k++) exp_q.push_back(r);
    endtask

    task automatic push_done(input logic ack);
        exp_q.push_back(done_rec(ack));
        push_n(TAIL - 1, done_rec(1'b0));
    endtask

    task automatic build_full();
        exp_q.delete();
        push_n(CNT_WAIT, idle_rec());
        exp_q.push_back(cmd_rec(4'b0010));
        push_n(TRP_CYC, idle_rec());
        for (int a = 0; a < AR_NUM; a++) begin
            exp_q.push_back(cmd_rec(4'b0001));
            push_n(TRFC_CYC, idle_rec());
        end
        exp_q.push_back(mrs_rec(m_cas, m_bl));
        push_n(TMRD_CYC, idle_rec());
        push_done(1'b0);
    endtask

    task automatic build_reload();
        exp_q.delete();
        exp_q.push_back(cmd_rec(4'b0010));
        push_n(TRP_CYC, idle_rec());
        exp_q.push_back(mrs_rec(m_cas, m_bl));
        push_n(TMRD_CYC, idle_rec());
        push_done(1'b1);
    endtask

    task automatic check(input string tag, input int idx, input rec_t e);
        rec_t o = observed();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, o, e);
        end
    endtask

    task automatic run_trace(input string tag, input int n, input bit inject);
        for (int i = 0; i < n; i++) begin
            @(posedge init_clk);
            #1 mrs_req = 1'b0;
            @(negedge init_clk);
            check(tag, i, exp_q[i]);
            if (inject && i + 1 < exp_q.size() && exp_q[i+1].busy && $urandom_range(0, 2) == 0) begin
                mrs_req = 1'b1;
                mrs_cas = 3'($urandom);
                mrs_bl  = 3'($urandom);
            end
        end
        mrs_req = 1'b0;
    endtask

    task automatic request(input logic ir, input logic mr, input logic [2:0] c, input logic [2:0] b);
        init_req = ir;
        mrs_req  = mr;
        mrs_cas  = c;
        mrs_bl   = b;
        @(posedge init_clk);
        #1;
        init_req = 1'b0;
        mrs_req  = 1'b0;
        if (ir) begin
            m_cas = 3'b011;
            m_bl  = 3'b111;
            build_full();
        end else if (mr) begin
            m_cas = c;
            m_bl  = b;
            build_reload();
        end
    endtask

    task automatic idle_done(input string tag, input int n);
        exp_q.delete();
        push_n(n, done_rec(1'b0));
        run_trace(tag, n, 1'b0);
    endtask

    initial begin
        m_cas = 3'b011;
        m_bl  = 3'b111;
        repeat (3) @(posedge init_clk);
        @(negedge init_clk);
        check("reset", 0, idle_rec());

        init_rst_n = 1'b1;
        build_full();
        run_trace("boot", exp_q.size(), 1'b0);

        request(1'b0, 1'b1, 3'b010, 3'b011);
        run_trace("mrs_dir", exp_q.size(), 1'b1);

        for (int r = 0; r < 3; r++) begin
            idle_done("idle", $urandom_range(1, 4));
            request(1'b0, 1'b1, 3'($urandom), 3'($urandom));
            run_trace("mrs_rand", exp_q.size(), 1'b1);
        end

        idle_done("idle", 2);
        request(1'b1, 1'b0, 3'($urandom), 3'($urandom));
        run_trace("reinit", exp_q.size(), 1'b1);

        request(1'b1, 1'b1, 3'b101, 3'b001);
        run_trace("both", exp_q.size(), 1'b1);

        request(1'b1, 1'b0, 3'b000, 3'b000);
        run_trace("pre_rst", $urandom_range(24, 29), 1'b0);
        init_rst_n = 1'b0;
        #1 check("rst_async", 0, idle_rec());
        @(posedge init_clk);
        @(negedge init_clk);
        check("rst_hold", 0, idle_rec());
        init_rst_n = 1'b1;
        m_cas = 3'b011;
        m_bl  = 3'b111;
        build_full();
        run_trace("post_rst", exp_q.size(), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_init_ctrl.md
SDRAM_INIT_CTRL -- requirements
Module: sdram_init_ctrl

Interface
REQ-001 SHALL use one clock and one reset. The reset is asynchronous and active-low. The ports are init_clk and init_rst_n.
REQ-002 SHALL have these parameters (name, default, meaning):
- ADDR_W, 13, SDRAM address width (minimum 11).
- BANK_W, 2, bank address width.
- CNT_WAIT, 10000, power-up wait in cycles.
- AR_NUM, 8, auto-refresh commands per init (1..15).
- TRP_CYC, 2, tRP in cycles.
- TRFC_CYC, 7, tRFC in cycles.
- TMRD_CYC, 2, tMRD in cycles.
- CAS_LAT, 3'b011, default CAS latency code.
- BURST_LEN, 3'b111, default burst-length code.
- ADDR_MODE, 1'b0, 0 = sequential, 1 = interleave.
- WRITE_MODE, 1'b0, A9 single-write bit.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- init_clk, in, 1, clock.
- init_rst_n, in, 1, asynchronous active-low reset.
- init_req, in, 1, full re-initialisation request pulse.
- mrs_req, in, 1, mode-register reload request pulse.
- mrs_cas, in, 3, CAS code for reload.
- mrs_bl, in, 3, burst code for reload.
- init_cmd, out, 4, {CS#,RAS#,CAS#,WE#}.
- init_bank, out, BANK_W, bank address.
- init_addr, out, ADDR_W, address.
- init_end, out, 1, initialised and idle.
- init_busy, out, 1, a sequence is in progress.
- mrs_ack, out, 1, one-cycle pulse when a reload completes.

Function
REQ-004 SHALL encode commands as NOP 4'b0111, PRE 4'b0010, AR 4'b0001, MRS 4'b0000.
REQ-005 SHALL implement FSM states WAIT, PRE, TRP, AR, TRFC, MRS, TMRD, DONE.
REQ-006 SHALL hold WAIT until the wait counter reaches CNT_WAIT-1, then go to PRE. The wait counter clears on entry to WAIT and saturates.
REQ-007 SHALL remain in PRE, AR and MRS for exactly 1 cycle each.
REQ-008 SHALL remain in TRP for TRP_CYC cycles, TRFC for TRFC_CYC cycles and TMRD for TMRD_CYC cycles. Each uses one shared cycle counter, cleared on every state change.
REQ-009 SHALL route TRP to AR for a full init and TRP to MRS for a reload.
REQ-010 SHALL count AR states; TRFC goes to AR while the count is below AR_NUM, otherwise to MRS.
REQ-011 SHALL go from TMRD to DONE; DONE holds until a request is accepted.
REQ-012 SHALL register init_cmd, init_bank and init_addr from the current state. Each command appears the cycle after its state is entered. Every non-MRS state drives all-ones on bank and address, so A10 = 1 and PRE selects all banks.
REQ-013 SHALL drive these in MRS:
- init_bank = 0.
- init_addr = {zeros, A9=WRITE_MODE, A8-7=0, A6-4=cas, A3=ADDR_MODE, A2-0=bl}.
- cas/bl come from the latched values.
REQ-014 SHALL load the latched cas/bl from CAS_LAT/BURST_LEN at reset and on an accepted init_req. On an accepted mrs_req they load from mrs_cas/mrs_bl.
REQ-015 SHALL accept init_req or mrs_req only in DONE; both are ignored in all other states.
- init_req goes to WAIT (full sequence, full CNT_WAIT).
- mrs_req goes to PRE with the reload flag set.
- If both are asserted in the same cycle, init_req wins and mrs_req is dropped.
REQ-016 SHALL register init_end = (state == DONE) and init_busy = (state != DONE), each one cycle after the state. init_end falls the cycle after a request is accepted.
REQ-017 SHALL pulse mrs_ack for 1 cycle, coincident with init_end rising, at the end of a reload only.
REQ-018 SHALL size the wait counter to $clog2(CNT_WAIT+1) bits, the cycle counter to 8 bits and the AR counter to 4 bits, with no wrap.

Reset
REQ-019 SHALL put the following in reset state while init_rst_n is low, including reset asserted mid-sequence:
- state = WAIT, all counters = 0, latched cas/bl = defaults.
- init_cmd = NOP, bank and address all-ones.
- init_end = 0, init_busy = 1, mrs_ack = 0.
REQ-020 SHALL begin a full init automatically after reset is released.

Structure
REQ-021 SHALL place command encodings, state encodings and the MRS field-packing function in shared package sdram_pkg.
REQ-022 SHALL be a single module with no sub-modules; the timers are inline counters.

Verification
All scenarios use CNT_WAIT=20, AR_NUM=2, TRP_CYC=2, TRFC_CYC=7, TMRD_CYC=2, ADDR_W=13.
REQ-023 Release reset:
- NOP is output until PRE with addr 13'h1FFF.
- AR follows PRE by 3 cycles; exactly 2 AR commands, 8 cycles apart.
- MRS comes 8 cycles after the last AR, with addr 13'h0037 and bank 0.
- init_end rises 3 cycles after MRS.
REQ-024 mrs_req with mrs_cas=3'b010, mrs_bl=3'b011 in DONE:
- PRE, then MRS 3 cycles later with addr 13'h0023 and no AR.
- mrs_ack and init_end rise together 3 cycles after MRS.
REQ-025 init_req in DONE -> init_end drops next cycle; the full sequence repeats with MRS addr back to 13'h0037.
REQ-026 init_req and mrs_req in the same cycle -> full init runs and mrs_ack never pulses; mrs_req during busy is ignored.
REQ-027 Reset asserted in TRFC after the first AR -> outputs return to NOP/all-ones immediately; after release, a full sequence with 2 AR commands follows.
